// File: rtl/multicycle_ctrl_fsm_if.sv
// Control bundle between the multi-cycle RV32I controller (master) and its datapath (slave).
// Optional macro PERF_CNT_EN adds the instret counter field.
interface multicycle_ctrl_fsm_if #(
  parameter int CNT_WIDTH = 32
);
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7_5;
  logic       EQ;
  logic       mem_ready;
  logic       mem_req;
  logic       AdrSrc;
  logic       MemWrite;
  logic       IRWrite;
  logic       PCWrite;
  logic       RegWrite;
  logic [1:0] ResultSrc;
  logic [1:0] ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [2:0] ALUctrl;
  logic [2:0] ImmSrc;
  logic       instr_done;
  logic       illegal;
`ifdef PERF_CNT_EN
  logic [CNT_WIDTH-1:0] instret;

  modport master (
    input  op, funct3, funct7_5, EQ, mem_ready,
    output mem_req, AdrSrc, MemWrite, IRWrite, PCWrite, RegWrite,
    output ResultSrc, ALUSrcA, ALUSrcB, ALUctrl, ImmSrc, instr_done, illegal, instret
  );
  modport slave (
    output op, funct3, funct7_5, EQ, mem_ready,
    input  mem_req, AdrSrc, MemWrite, IRWrite, PCWrite, RegWrite,
    input  ResultSrc, ALUSrcA, ALUSrcB, ALUctrl, ImmSrc, instr_done, illegal, instret
  );
`else
  if (CNT_WIDTH < 1) begin : g_bad_cnt_width
  end

  modport master (
    input  op, funct3, funct7_5, EQ, mem_ready,
    output mem_req, AdrSrc, MemWrite, IRWrite, PCWrite, RegWrite,
    output ResultSrc, ALUSrcA, ALUSrcB, ALUctrl, ImmSrc, instr_done, illegal
  );
  modport slave (
    output op, funct3, funct7_5, EQ, mem_ready,
    input  mem_req, AdrSrc, MemWrite, IRWrite, PCWrite, RegWrite,
    input  ResultSrc, ALUSrcA, ALUSrcB, ALUctrl, ImmSrc, instr_done, illegal
  );
`endif
endinterface

// File: rtl/multicycle_ctrl_fsm.sv
// Main controller of the multi-cycle RV32I core; latency load 5, store/ALU/JAL 4, branch 3 cycles.
// Memory waits stretch FETCH/MEMREAD/MEMWRITE while mem_ready is low. Macro PERF_CNT_EN adds instret.
module multicycle_ctrl_fsm #(
  parameter int CNT_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  multicycle_ctrl_fsm_if.master  bus
);

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE,
    EXECR, EXECI, ALUWB, BRANCH, JAL, TRAP
  } state_t;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;

  state_t     r_state;
  logic       r_illegal;
  logic [2:0] w_alu_dec;
  logic       w_taken;
  logic       w_instr_done;

  // funct3/funct7_5 decode shared by EXECR and EXECI; only R-type honours the sub bit
  always_comb begin
    w_alu_dec = ALU_ADD;
    case (bus.funct3)
      3'b000:  w_alu_dec = (bus.funct7_5 && (r_state == EXECR)) ? ALU_SUB : ALU_ADD;
      3'b111:  w_alu_dec = 3'b010;
      3'b110:  w_alu_dec = 3'b011;
      3'b100:  w_alu_dec = 3'b100;
      3'b010:  w_alu_dec = 3'b101;
      3'b001:  w_alu_dec = 3'b110;
      3'b101:  w_alu_dec = 3'b111;
      default: w_alu_dec = ALU_ADD;
    endcase
  end

  assign w_taken = ((bus.funct3 == 3'b000) &&  bus.EQ) ||
                   ((bus.funct3 == 3'b001) && !bus.EQ);

  // Outputs decode the state register directly so rst and mem_ready take effect in the same cycle
  always_comb begin
    bus.mem_req    = 1'b0;
    bus.AdrSrc     = 1'b0;
    bus.MemWrite   = 1'b0;
    bus.IRWrite    = 1'b0;
    bus.PCWrite    = 1'b0;
    bus.RegWrite   = 1'b0;
    bus.ResultSrc  = 2'b00;
    bus.ALUSrcA    = 2'b00;
    bus.ALUSrcB    = 2'b00;
    bus.ALUctrl    = ALU_ADD;
    bus.ImmSrc     = 3'b000;
    w_instr_done   = 1'b0;
    if (!rst) begin
      case (bus.op)
        OP_STORE: bus.ImmSrc = 3'b001;
        OP_BR:    bus.ImmSrc = 3'b010;
        OP_JAL:   bus.ImmSrc = 3'b011;
        default:  bus.ImmSrc = 3'b000;
      endcase
      case (r_state)
        FETCH: begin
          bus.mem_req   = 1'b1;
          bus.ALUSrcB   = 2'b10;
          bus.ResultSrc = 2'b10;
          bus.IRWrite   = bus.mem_ready;
          bus.PCWrite   = bus.mem_ready;
        end
        DECODE: begin
          bus.ALUSrcA = 2'b01;
          bus.ALUSrcB = 2'b01;
        end
        MEMADR: begin
          bus.ALUSrcA = 2'b10;
          bus.ALUSrcB = 2'b01;
        end
        MEMREAD: begin
          bus.mem_req = 1'b1;
          bus.AdrSrc  = 1'b1;
        end
        MEMWB: begin
          bus.ResultSrc = 2'b01;
          bus.RegWrite  = 1'b1;
          w_instr_done  = 1'b1;
        end
        MEMWRITE: begin
          bus.mem_req  = 1'b1;
          bus.AdrSrc   = 1'b1;
          bus.MemWrite = 1'b1;
          w_instr_done = bus.mem_ready;
        end
        EXECR: begin
          bus.ALUSrcA = 2'b10;
          bus.ALUctrl = w_alu_dec;
        end
        EXECI: begin
          bus.ALUSrcA = 2'b10;
          bus.ALUSrcB = 2'b01;
          bus.ALUctrl = w_alu_dec;
        end
        ALUWB: begin
          bus.RegWrite = 1'b1;
          w_instr_done = 1'b1;
        end
        BRANCH: begin
          bus.ALUSrcA  = 2'b10;
          bus.ALUctrl  = ALU_SUB;
          bus.PCWrite  = w_taken;
          w_instr_done = 1'b1;
        end
        JAL: begin
          bus.ALUSrcA = 2'b01;
          bus.ALUSrcB = 2'b10;
          bus.PCWrite = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.instr_done = w_instr_done;
  assign bus.illegal    = r_illegal & ~rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= FETCH;
      r_illegal <= 1'b0;
    end else begin
      case (r_state)
        FETCH:    if (bus.mem_ready) r_state <= DECODE;
        DECODE: begin
          case (bus.op)
            OP_LOAD, OP_STORE: r_state <= MEMADR;
            OP_R:              r_state <= EXECR;
            OP_I:              r_state <= EXECI;
            OP_BR:             r_state <= BRANCH;
            OP_JAL:            r_state <= JAL;
            default: begin
              r_state   <= TRAP;
              r_illegal <= 1'b1;
            end
          endcase
        end
        MEMADR:   r_state <= (bus.op == OP_LOAD) ? MEMREAD : MEMWRITE;
        MEMREAD:  if (bus.mem_ready) r_state <= MEMWB;
        MEMWB:    r_state <= FETCH;
        MEMWRITE: if (bus.mem_ready) r_state <= FETCH;
        EXECR:    r_state <= ALUWB;
        EXECI:    r_state <= ALUWB;
        ALUWB:    r_state <= FETCH;
        BRANCH:   r_state <= FETCH;
        JAL:      r_state <= ALUWB;
        TRAP:     r_state <= TRAP;
        default:  r_state <= FETCH;
      endcase
    end
  end

`ifdef PERF_CNT_EN
  logic [CNT_WIDTH-1:0] r_instret;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_instret <= '0;
    end else if (w_instr_done) begin
      r_instret <= r_instret + CNT_WIDTH'(1);
    end
  end

  assign bus.instret = rst ? '0 : r_instret;
`else
  if (CNT_WIDTH < 1) begin : g_bad_cnt_width
  end
`endif

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Self-checking bench for multicycle_ctrl_fsm: directed vector table, hand-written corner cases,
// and random instruction streams checked against a per-instruction cycle-sequence model.
module tb_multicycle_ctrl_fsm;

  logic clk;
  logic rst;
  int   n_total;
  int   n_bad;

  multicycle_ctrl_fsm_if #(.CNT_WIDTH(32)) bus ();

  multicycle_ctrl_fsm #(.CNT_WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [19:0] act_v;
  assign act_v = {bus.mem_req, bus.AdrSrc, bus.MemWrite, bus.IRWrite, bus.PCWrite,
                  bus.RegWrite, bus.ResultSrc, bus.ALUSrcA, bus.ALUSrcB, bus.ALUctrl,
                  bus.ImmSrc, bus.instr_done, bus.illegal};

  task automatic check(input string nm, input logic [31:0] a, input logic [31:0] e);
    n_total++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, a, e, $time);
    end
  endtask

  // ---------------- reference model: expected cycle sequence per instruction ----------------
  typedef struct {
    logic        mr;
    logic        eq;
    logic [19:0] exp;
  } vec_t;

  vec_t        q[$];
  logic [2:0]  cur_imm;
  int          exp_instret;

  function automatic logic [2:0] imm_of(input logic [6:0] op);
    case (op)
      7'b0100011: return 3'b001;
      7'b1100011: return 3'b010;
      7'b1101111: return 3'b011;
      default:    return 3'b000;
    endcase
  endfunction

  function automatic logic [2:0] alu_of(input logic [2:0] f3, input logic f7, input logic is_r);
    case (f3)
      3'b000:  return (is_r && f7) ? 3'b001 : 3'b000;
      3'b111:  return 3'b010;
      3'b110:  return 3'b011;
      3'b100:  return 3'b100;
      3'b010:  return 3'b101;
      3'b001:  return 3'b110;
      3'b101:  return 3'b111;
      default: return 3'b000;
    endcase
  endfunction

  function automatic logic [19:0] mk(input logic mreq, input logic adr, input logic mw,
                                     input logic irw, input logic pcw, input logic rw,
                                     input logic [1:0] rs, input logic [1:0] sa,
                                     input logic [1:0] sb, input logic [2:0] alu,
                                     input logic done, input logic ill);
    return {mreq, adr, mw, irw, pcw, rw, rs, sa, sb, alu, cur_imm, done, ill};
  endfunction

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic push(input logic mr, input logic eq, input logic [19:0] e);
    vec_t v;
    v.mr = mr; v.eq = eq; v.exp = e;
    q.push_back(v);
  endtask

  // cls: 0 load, 1 store, 2 R, 3 I, 4 branch, 5 jal, 6 unsupported
  task automatic gen(input int cls, input logic [6:0] op, input logic [2:0] f3, input logic f7,
                     input int fw, input int mwait);
    logic eq;
    cur_imm = imm_of(op);
    for (int k = 0; k < fw; k++) push(1'b0, rbit(), mk(1,0,0,0,0,0,2'b10,2'b00,2'b10,3'd0,0,0));
    push(1'b1, rbit(), mk(1,0,0,1,1,0,2'b10,2'b00,2'b10,3'd0,0,0));
    push(rbit(), rbit(), mk(0,0,0,0,0,0,2'b00,2'b01,2'b01,3'd0,0,0));
    case (cls)
      0: begin
        push(rbit(), rbit(), mk(0,0,0,0,0,0,2'b00,2'b10,2'b01,3'd0,0,0));
        for (int k = 0; k < mwait; k++) push(1'b0, rbit(), mk(1,1,0,0,0,0,2'b00,2'b00,2'b00,3'd0,0,0));
        push(1'b1, rbit(), mk(1,1,0,0,0,0,2'b00,2'b00,2'b00,3'd0,0,0));
        push(rbit(), rbit(), mk(0,0,0,0,0,1,2'b01,2'b00,2'b00,3'd0,1,0));
        exp_instret++;
      end
      1: begin
        push(rbit(), rbit(), mk(0,0,0,0,0,0,2'b00,2'b10,2'b01,3'd0,0,0));
        for (int k = 0; k < mwait; k++) push(1'b0, rbit(), mk(1,1,1,0,0,0,2'b00,2'b00,2'b00,3'd0,0,0));
        push(1'b1, rbit(), mk(1,1,1,0,0,0,2'b00,2'b00,2'b00,3'd0,1,0));
        exp_instret++;
      end
      2, 3: begin
        push(rbit(), rbit(), mk(0,0,0,0,0,0,2'b00,2'b10,(cls == 3) ? 2'b01 : 2'b00,
                                alu_of(f3, f7, cls == 2),0,0));
        push(rbit(), rbit(), mk(0,0,0,0,0,1,2'b00,2'b00,2'b00,3'd0,1,0));
        exp_instret++;
      end
      4: begin
        eq = rbit();
        push(rbit(), eq, mk(0,0,0,0,((f3 == 3'd0) && eq) || ((f3 == 3'd1) && !eq),0,
                            2'b00,2'b10,2'b00,3'd1,1,0));
        exp_instret++;
      end
      5: begin
        push(rbit(), rbit(), mk(0,0,0,0,1,0,2'b00,2'b01,2'b10,3'd0,0,0));
        push(rbit(), rbit(), mk(0,0,0,0,0,1,2'b00,2'b00,2'b00,3'd0,1,0));
        exp_instret++;
      end
      default: begin
        for (int k = 0; k < 6; k++) push(rbit(), rbit(), mk(0,0,0,0,0,0,2'b00,2'b00,2'b00,3'd0,0,1));
      end
    endcase
  endtask

  // Entered at posedge+1; leaves at posedge+1 after the last vector.
  task automatic apply(input string nm, input logic [6:0] op, input logic [2:0] f3, input logic f7);
    vec_t v;
    bus.op = op; bus.funct3 = f3; bus.funct7_5 = f7;
    while (q.size() > 0) begin
      v = q.pop_front();
      bus.mem_ready = v.mr;
      bus.EQ        = v.eq;
      @(negedge clk);
      check(nm, 32'(act_v), 32'(v.exp));
      @(posedge clk); #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    check("reset_outputs", 32'(act_v), 32'd0);
`ifdef PERF_CNT_EN
    check("reset_instret", bus.instret, 32'd0);
`endif
    @(posedge clk); #1;
    rst = 1'b0;
    exp_instret = 0;
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic [6:0] op;
    logic [2:0] f3;
    logic       f7;
    logic       eq;
    int         w;
    int         len;
    int         rw;
    int         pcw;
    int         mreq;
    logic [2:0] alu2;
  } dir_t;

  dir_t tbl[20];

  task automatic run_directed(input int i);
    int len, rw, pcw, mreq;
    logic [2:0] alu2;
    logic done;
    len = 0; rw = 0; pcw = 0; mreq = 0; alu2 = 3'bx;
    bus.op = tbl[i].op; bus.funct3 = tbl[i].f3; bus.funct7_5 = tbl[i].f7; bus.EQ = tbl[i].eq;
    for (int c = 0; c < 20; c++) begin
      bus.mem_ready = !((c >= 3) && (c < 3 + tbl[i].w));
      @(negedge clk);
      rw   += int'(bus.RegWrite);
      pcw  += int'(bus.PCWrite);
      mreq += int'(bus.mem_req);
      if (c == 2) alu2 = bus.ALUctrl;
      done = bus.instr_done;
      @(posedge clk); #1;
      if (done) begin
        len = c + 1;
        break;
      end
    end
    check($sformatf("dir%0d_len", i), len, tbl[i].len);
    check($sformatf("dir%0d_regwrite", i), rw, tbl[i].rw);
    check($sformatf("dir%0d_pcwrite", i), pcw, tbl[i].pcw);
    check($sformatf("dir%0d_memreq", i), mreq, tbl[i].mreq);
    check($sformatf("dir%0d_alu", i), 32'(alu2), 32'(tbl[i].alu2));
  endtask

  initial begin
    int cls, fw, mw;
    logic [6:0] op;
    logic [2:0] f3;
    logic f7;
    logic [6:0] ops[7];
    n_total = 0; n_bad = 0; exp_instret = 0;
    rst = 1'b1;
    bus.op = '0; bus.funct3 = '0; bus.funct7_5 = 1'b0; bus.EQ = 1'b0; bus.mem_ready = 1'b0;
    ops[0] = 7'b0000011; ops[1] = 7'b0100011; ops[2] = 7'b0110011; ops[3] = 7'b0010011;
    ops[4] = 7'b1100011; ops[5] = 7'b1101111; ops[6] = 7'b1111111;

    //           op          f3     f7  eq  w  len rw pcw mreq alu@cycle2
    tbl[0]  = '{7'b0010011, 3'b000, 0, 0, 0, 4, 1, 1, 1, 3'b000};
    tbl[1]  = '{7'b0010011, 3'b000, 1, 0, 0, 4, 1, 1, 1, 3'b000};
    tbl[2]  = '{7'b0110011, 3'b000, 1, 0, 0, 4, 1, 1, 1, 3'b001};
    tbl[3]  = '{7'b0110011, 3'b000, 0, 0, 0, 4, 1, 1, 1, 3'b000};
    tbl[4]  = '{7'b0110011, 3'b111, 0, 0, 0, 4, 1, 1, 1, 3'b010};
    tbl[5]  = '{7'b0010011, 3'b110, 0, 0, 0, 4, 1, 1, 1, 3'b011};
    tbl[6]  = '{7'b0010011, 3'b100, 0, 0, 0, 4, 1, 1, 1, 3'b100};
    tbl[7]  = '{7'b0110011, 3'b010, 0, 0, 0, 4, 1, 1, 1, 3'b101};
    tbl[8]  = '{7'b0010011, 3'b001, 0, 0, 0, 4, 1, 1, 1, 3'b110};
    tbl[9]  = '{7'b0110011, 3'b101, 0, 0, 0, 4, 1, 1, 1, 3'b111};
    tbl[10] = '{7'b0000011, 3'b010, 0, 0, 0, 5, 1, 1, 2, 3'b000};
    tbl[11] = '{7'b0000011, 3'b010, 0, 0, 2, 7, 1, 1, 4, 3'b000};
    tbl[12] = '{7'b0100011, 3'b010, 0, 0, 0, 4, 0, 1, 2, 3'b000};
    tbl[13] = '{7'b0100011, 3'b010, 0, 0, 1, 5, 0, 1, 3, 3'b000};
    tbl[14] = '{7'b1100011, 3'b000, 0, 1, 0, 3, 0, 2, 1, 3'b001};
    tbl[15] = '{7'b1100011, 3'b000, 0, 0, 0, 3, 0, 1, 1, 3'b001};
    tbl[16] = '{7'b1100011, 3'b001, 0, 0, 0, 3, 0, 2, 1, 3'b001};
    tbl[17] = '{7'b1100011, 3'b001, 0, 1, 0, 3, 0, 1, 1, 3'b001};
    tbl[18] = '{7'b1100011, 3'b100, 0, 1, 0, 3, 0, 1, 1, 3'b001};
    tbl[19] = '{7'b1101111, 3'b000, 0, 0, 0, 4, 1, 2, 1, 3'b000};

    for (int i = 0; i < 20; i++) begin
      do_reset();
      run_directed(i);
    end

    // Unsupported opcode: trap is sticky and strobe-free until reset, which clears illegal
    do_reset();
    gen(6, 7'b1111111, 3'b000, 1'b0, 0, 0);
    apply("trap_seq", 7'b1111111, 3'b000, 1'b0);
    do_reset();
    @(negedge clk);
    check("illegal_cleared", 32'(bus.illegal), 32'd0);
    @(posedge clk); #1;

    // Reset during a store wait drops the strobes in the same cycle and restarts in FETCH
    do_reset();
    bus.op = 7'b0100011; bus.funct3 = 3'b010; bus.funct7_5 = 1'b0;
    bus.mem_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
    end
    bus.mem_ready = 1'b0;
    @(negedge clk);
    check("st_wait_strobes", 32'({bus.mem_req, bus.MemWrite}), 32'd3);
    #1 rst = 1'b1;
    #1 check("st_rst_drop", 32'({bus.mem_req, bus.MemWrite}), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    cur_imm = imm_of(7'b0100011);
    @(negedge clk);
    check("fetch_after_rst", 32'(act_v), 32'(mk(1,0,0,0,0,0,2'b10,2'b00,2'b10,3'd0,0,0)));
    @(posedge clk); #1;

`ifdef PERF_CNT_EN
    do_reset();
    for (int i = 0; i < 3; i++) begin
      gen(3, 7'b0010011, 3'b000, 1'b0, 0, 0);
      apply("three_addi", 7'b0010011, 3'b000, 1'b0);
    end
    @(negedge clk);
    check("instret_three", bus.instret, 32'd3);
    @(posedge clk); #1;
    do_reset();
    @(negedge clk);
    check("instret_cleared", bus.instret, 32'd0);
    @(posedge clk); #1;
`endif

    // Random instruction stream against the sequence model
    do_reset();
    for (int n = 0; n < 200; n++) begin
      cls = $urandom_range(0, 5);
      op  = ops[cls];
      f3  = 3'($urandom_range(0, 7));
      f7  = rbit();
      fw  = $urandom_range(0, 2);
      mw  = $urandom_range(0, 2);
      gen(cls, op, f3, f7, fw, mw);
      apply("rand_cycle", op, f3, f7);
    end
`ifdef PERF_CNT_EN
    @(negedge clk);
    check("rand_instret", bus.instret, 32'(exp_instret));
    @(posedge clk); #1;
`endif
    gen(6, 7'b0110111, 3'($urandom_range(0, 7)), 1'b0, 1, 0);
    apply("rand_trap", 7'b0110111, 3'b000, 1'b0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
